// File: rtl/counter_run_ctrl.sv
// W-bit counter run controller: load, count up/down, stop or reload at a terminal value.
// Optional prescaler enabled by defining CNT_PRESCALE_EN.
module counter_run_ctrl #(
   parameter int W     = 4,
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode_up,
   input  logic             one_shot,
   input  logic [W-1:0]     load_val,
   input  logic [W-1:0]     term_val,
`ifdef CNT_PRESCALE_EN
   input  logic [PRE_W-1:0] presc_div,
`endif
   output logic [W-1:0]     count,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t       state, state_n;
   logic [W-1:0] count_n;
   logic         busy_n, done_n, wrap_n;

   logic         up_q, os_q;
   logic [W-1:0] load_q, term_q;
   logic         cfg_en;
   logic         step;
   logic         presc_clr;

`ifdef CNT_PRESCALE_EN
   logic [PRE_W-1:0] div_q;
   logic [PRE_W-1:0] presc, presc_n;

   assign step = (presc == div_q);
`else
   logic [PRE_W-1:0] unused_presc;

   assign unused_presc = '0;
   assign step         = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         busy  <= busy_n;
         done  <= done_n;
         wrap  <= wrap_n;
      end
   end

   // Configuration is captured only at an accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         up_q   <= 1'b0;
         os_q   <= 1'b0;
         load_q <= '0;
         term_q <= '0;
      end else if (cfg_en) begin
         up_q   <= mode_up;
         os_q   <= one_shot;
         load_q <= load_val;
         term_q <= term_val;
      end
   end

`ifdef CNT_PRESCALE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         presc <= '0;
      end else begin
         if (cfg_en)
            div_q <= presc_div;
         presc <= presc_n;
      end
   end

   always_comb begin
      presc_n = presc;
      if (presc_clr)
         presc_n = '0;
      else if ((state == RUN || state == PAUSE) && !pause)
         presc_n = step ? '0 : presc + 1'b1;
   end
`endif

   always_comb begin
      state_n   = state;
      count_n   = count;
      done_n    = 1'b0;
      wrap_n    = 1'b0;
      cfg_en    = 1'b0;
      presc_clr = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !stop) begin
               state_n   = RUN;
               count_n   = load_val;
               cfg_en    = 1'b1;
               presc_clr = 1'b1;
            end
         end
         RUN, PAUSE: begin
            if (stop) begin
               state_n   = IDLE;
               presc_clr = 1'b1;
            end else if (pause) begin
               state_n = PAUSE;
            end else begin
               state_n = RUN;
               if (step) begin
                  if (count == term_q) begin
                     presc_clr = 1'b1;
                     if (os_q) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                     end else begin
                        count_n = load_q;
                        wrap_n  = 1'b1;
                     end
                  end else begin
                     count_n = up_q ? count + 1'b1 : count - 1'b1;
                  end
               end
            end
         end
         DONE: begin
            state_n   = IDLE;
            presc_clr = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n == RUN) || (state_n == PAUSE);
   end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl (W=4), immediate-assertion checks.
module tb_counter_run_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, stop, pause, mode_up, one_shot;
   logic [3:0] load_val, term_val;
   logic [3:0] count;
   logic       busy, done, wrap;
`ifdef CNT_PRESCALE_EN
   logic [7:0] presc_div;
`endif

   int vectors     = 0;
   int miscompares = 0;

   counter_run_ctrl #(.W(4), .PRE_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .mode_up  (mode_up),
      .one_shot (one_shot),
      .load_val (load_val),
      .term_val (term_val),
`ifdef CNT_PRESCALE_EN
      .presc_div(presc_div),
`endif
      .count    (count),
      .busy     (busy),
      .done     (done),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] c,
                          input logic b, input logic d, input logic w);
      chk({tag, ".count"}, {4'd0, count}, {4'd0, c});
      chk({tag, ".busy"},  {7'd0, busy},  {7'd0, b});
      chk({tag, ".done"},  {7'd0, done},  {7'd0, d});
      chk({tag, ".wrap"},  {7'd0, wrap},  {7'd0, w});
   endtask

   task automatic go(input logic [3:0] ld, input logic [3:0] tm,
                     input logic up, input logic os);
      load_val = ld;
      term_val = tm;
      mode_up  = up;
      one_shot = os;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      // scramble config to prove it was latched
      load_val = ~ld;
      term_val = ~tm;
      mode_up  = ~up;
      one_shot = ~os;
   endtask

   initial begin
      rst = 1'b1; start = 0; stop = 0; pause = 0;
      mode_up = 0; one_shot = 0; load_val = 0; term_val = 0;
`ifdef CNT_PRESCALE_EN
      presc_div = 8'd0;
`endif
      tick();
      tick();
      rst = 1'b0;
      chk_out("reset", 4'd0, 0, 0, 0);

      // one-shot up 2..5, start during DONE ignored
      go(4'd2, 4'd5, 1, 1);
      chk_out("t1_c2", 4'd2, 1, 0, 0);
      tick(); chk_out("t1_c3", 4'd3, 1, 0, 0);
      tick(); chk_out("t1_c4", 4'd4, 1, 0, 0);
      tick(); chk_out("t1_c5", 4'd5, 1, 0, 0);
      tick(); chk_out("t1_done", 4'd5, 0, 1, 0);
      start = 1'b1;
      tick(); chk_out("t1_idle", 4'd5, 0, 0, 0);
      start = 1'b0;
      tick(); chk_out("t1_idle2", 4'd5, 0, 0, 0);

      // continuous up across 15->0
      go(4'd14, 4'd1, 1, 0);
      chk_out("t2_14", 4'd14, 1, 0, 0);
      tick(); chk_out("t2_15", 4'd15, 1, 0, 0);
      tick(); chk_out("t2_0", 4'd0, 1, 0, 0);
      tick(); chk_out("t2_1", 4'd1, 1, 0, 0);
      tick(); chk_out("t2_wrap", 4'd14, 1, 0, 1);
      tick(); chk_out("t2_15b", 4'd15, 1, 0, 0);
      stop = 1'b1;
      tick(); chk_out("t2_stop", 4'd15, 0, 0, 0);
      stop = 1'b0;

      // continuous down across 0->15
      go(4'd1, 4'd14, 0, 0);
      chk_out("td_1", 4'd1, 1, 0, 0);
      tick(); chk_out("td_0", 4'd0, 1, 0, 0);
      tick(); chk_out("td_15", 4'd15, 1, 0, 0);
      tick(); chk_out("td_14", 4'd14, 1, 0, 0);
      tick(); chk_out("td_wrap", 4'd1, 1, 0, 1);
      stop = 1'b1;
      tick(); chk_out("td_stop", 4'd1, 0, 0, 0);
      stop = 1'b0;

      // load == term, down one-shot
      go(4'd3, 4'd3, 0, 1);
      chk_out("t3_c3", 4'd3, 1, 0, 0);
      tick(); chk_out("t3_done", 4'd3, 0, 1, 0);
      tick(); chk_out("t3_idle", 4'd3, 0, 0, 0);

      // pause then stop
      go(4'd0, 4'd9, 1, 1);
      chk_out("t4_c0", 4'd0, 1, 0, 0);
      tick(); chk_out("t4_c1", 4'd1, 1, 0, 0);
      tick(); chk_out("t4_c2", 4'd2, 1, 0, 0);
      pause = 1'b1;
      tick(); chk_out("t4_p4", 4'd2, 1, 0, 0);
      tick(); chk_out("t4_p5", 4'd2, 1, 0, 0);
      tick(); chk_out("t4_p6", 4'd2, 1, 0, 0);
      pause = 1'b0;
      tick(); chk_out("t4_res", 4'd3, 1, 0, 0);
      stop = 1'b1; pause = 1'b1;
      tick(); chk_out("t4_stop", 4'd3, 0, 0, 0);
      stop = 1'b0; pause = 1'b0;
      tick(); chk_out("t4_idle", 4'd3, 0, 0, 0);

      // stop beats terminal detection
      go(4'd6, 4'd6, 1, 1);
      chk_out("ts_c6", 4'd6, 1, 0, 0);
      stop = 1'b1;
      tick(); chk_out("ts_stop", 4'd6, 0, 0, 0);
      stop = 1'b0;

      // reset mid-run, then start+stop together
      go(4'd5, 4'd0, 0, 1);
      chk_out("t5_c5", 4'd5, 1, 0, 0);
      tick(); chk_out("t5_c4", 4'd4, 1, 0, 0);
      rst = 1'b1;
      tick(); chk_out("t5_rst", 4'd0, 0, 0, 0);
      rst = 1'b0;
      start = 1'b1; stop = 1'b1; load_val = 4'd7;
      tick(); chk_out("t5_ss", 4'd0, 0, 0, 0);
      start = 1'b0; stop = 1'b0;
      tick(); chk_out("t5_idle", 4'd0, 0, 0, 0);

`ifdef CNT_PRESCALE_EN
      presc_div = 8'd2;
      go(4'd0, 4'd2, 1, 1);
      presc_div = 8'd0;
      chk_out("t6_c0", 4'd0, 1, 0, 0);
      tick(); chk_out("t6_a", 4'd0, 1, 0, 0);
      tick(); chk_out("t6_b", 4'd0, 1, 0, 0);
      tick(); chk_out("t6_c1", 4'd1, 1, 0, 0);
      tick(); chk_out("t6_d", 4'd1, 1, 0, 0);
      tick(); chk_out("t6_e", 4'd1, 1, 0, 0);
      tick(); chk_out("t6_c2", 4'd2, 1, 0, 0);
      tick(); chk_out("t6_f", 4'd2, 1, 0, 0);
      tick(); chk_out("t6_g", 4'd2, 1, 0, 0);
      tick(); chk_out("t6_done", 4'd2, 0, 1, 0);
      tick(); chk_out("t6_idle", 4'd2, 0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
